// File: rtl/place_cmd_sched_pkg.sv
// Shared types for the placement command scheduler: command format, op codes, FSM states.
package place_pkg;

  localparam int unsigned CMD_W = 27;

  typedef enum logic [1:0] {
    ADD_IMG = 2'd0,
    REM_IMG = 2'd1,
    ADD_FNT = 2'd2,
    OP_RSVD = 2'd3
  } op_t;

  typedef struct packed {
    op_t        op;
    logic [5:0] indx;
    logic [9:0] xloc;
    logic [8:0] yloc;
  } place_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_WAIT
  } sched_state_t;

endpackage

// File: rtl/place_cmd_sched_cmd_fifo.sv
// Command FIFO: single-cycle push/pop, head presented combinationally, sync active-high reset.
module cmd_fifo
  import place_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNTW-1:0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNTW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNTW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/place_cmd_sched.sv
// Round-robin command scheduler feeding the placement engine one start pulse at a time.
// Optional macro VBLANK_GATE_EN adds a vblank input that gates popping in S_IDLE.
module place_cmd_sched
  import place_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_vld,
  input  logic [26:0]     a_cmd,
  output logic            a_rdy,
  input  logic            b_vld,
  input  logic [26:0]     b_cmd,
  output logic            b_rdy,
  input  logic            pb_busy,
`ifdef VBLANK_GATE_EN
  input  logic            vblank,
`endif
  output logic            add_img,
  output logic            rem_img,
  output logic            add_fnt,
  output logic [4:0]      image_indx,
  output logic [5:0]      fnt_indx,
  output logic [9:0]      xloc,
  output logic [8:0]      yloc,
  output logic [CNTW-1:0] fifo_cnt,
  output logic            sched_idle,
  output logic            err_op,
  input  logic            err_clr
);

  sched_state_t state_q, state_d;
  op_t          op_q, op_d;
  logic [5:0]   indx_q, indx_d;
  logic [9:0]   xloc_q, xloc_d;
  logic [8:0]   yloc_q, yloc_d;
  logic         last_a_q, last_a_d;
  logic         err_q, err_d;
  logic         err_set;

  logic         grant_a, grant_b, push, pop, full, empty, gate;
  logic [26:0]  push_data, head_raw;
  place_cmd_t   head;

`ifdef VBLANK_GATE_EN
  assign gate = vblank;
`else
  assign gate = 1'b1;
`endif

  cmd_fifo #(.DEPTH(DEPTH), .CNTW(CNTW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head_raw),
    .full      (full),
    .empty     (empty),
    .count     (fifo_cnt)
  );

  assign head = place_cmd_t'(head_raw);

  // last_a_q low means B was granted last (or reset), so A wins a tie.
  always_comb begin
    grant_a   = a_vld & (~b_vld | ~last_a_q);
    grant_b   = b_vld & ~grant_a;
    a_rdy     = grant_a & ~full;
    b_rdy     = grant_b & ~full;
    push      = a_rdy | b_rdy;
    push_data = a_rdy ? a_cmd : b_cmd;
    last_a_d  = push ? a_rdy : last_a_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    indx_d  = indx_q;
    xloc_d  = xloc_q;
    yloc_d  = yloc_q;
    pop     = 1'b0;
    err_set = 1'b0;
    add_img = 1'b0;
    rem_img = 1'b0;
    add_fnt = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && !pb_busy && gate) begin
          pop    = 1'b1;
          op_d   = head.op;
          indx_d = head.indx;
          xloc_d = head.xloc;
          yloc_d = head.yloc;
          if (head.op == OP_RSVD) err_set = 1'b1;
          else                    state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        case (op_q)
          ADD_IMG: add_img = 1'b1;
          REM_IMG: rem_img = 1'b1;
          ADD_FNT: add_fnt = 1'b1;
          default: ;
        endcase
        state_d = S_HOLD;
      end
      S_HOLD:  state_d = S_WAIT;
      S_WAIT:  if (!pb_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= ADD_IMG;
      indx_q   <= '0;
      xloc_q   <= '0;
      yloc_q   <= '0;
      last_a_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      indx_q   <= indx_d;
      xloc_q   <= xloc_d;
      yloc_q   <= yloc_d;
      last_a_q <= last_a_d;
      err_q    <= err_d;
    end
  end

  assign image_indx = indx_q[4:0];
  assign fnt_indx   = indx_q;
  assign xloc       = xloc_q;
  assign yloc       = yloc_q;
  assign err_op     = err_q;
  assign sched_idle = empty & (state_q == S_IDLE);

endmodule

// File: tb/tb_place_cmd_sched.sv
// Directed self-checking bench for place_cmd_sched (default DEPTH = 8).
module tb_place_cmd_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_vld = 1'b0, b_vld = 1'b0;
  logic [26:0] a_cmd = '0, b_cmd = '0;
  logic        a_rdy, b_rdy;
  logic        pb_busy = 1'b0;
`ifdef VBLANK_GATE_EN
  logic        vblank = 1'b1;
`endif
  logic        add_img, rem_img, add_fnt;
  logic [4:0]  image_indx;
  logic [5:0]  fnt_indx;
  logic [9:0]  xloc;
  logic [8:0]  yloc;
  logic [3:0]  fifo_cnt;
  logic        sched_idle, err_op;
  logic        err_clr = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  place_cmd_sched #(.DEPTH(8), .CNTW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_vld      (a_vld),
    .a_cmd      (a_cmd),
    .a_rdy      (a_rdy),
    .b_vld      (b_vld),
    .b_cmd      (b_cmd),
    .b_rdy      (b_rdy),
    .pb_busy    (pb_busy),
`ifdef VBLANK_GATE_EN
    .vblank     (vblank),
`endif
    .add_img    (add_img),
    .rem_img    (rem_img),
    .add_fnt    (add_fnt),
    .image_indx (image_indx),
    .fnt_indx   (fnt_indx),
    .xloc       (xloc),
    .yloc       (yloc),
    .fifo_cnt   (fifo_cnt),
    .sched_idle (sched_idle),
    .err_op     (err_op),
    .err_clr    (err_clr)
  );

  function automatic logic [26:0] mk(input logic [1:0] op, input logic [5:0] idx,
                                     input logic [9:0] x, input logic [8:0] y);
    return {op, idx, x, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pulses packed as {add_img, rem_img, add_fnt}
  task automatic chk_pulses(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, add_img, rem_img, add_fnt}, {29'd0, exp});
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_idle", sched_idle, 1);
    chk("rst_err", err_op, 0);
    chk_pulses("rst_pulses", 3'b000);
    chk("rst_loc", {image_indx, fnt_indx, xloc, yloc}, 0);

    // Single command from A
    a_vld = 1'b1; a_cmd = mk(2'd0, 6'd5, 10'd100, 9'd50);
    #1 chk("single_a_rdy", a_rdy, 1);
    chk("single_b_rdy", b_rdy, 0);
    tick(); a_vld = 1'b0;
    chk("single_cnt1", fifo_cnt, 1);
    chk_pulses("single_nopulse", 3'b000);
    tick();
    chk_pulses("single_pulse", 3'b100);
    chk("single_indx", image_indx, 5);
    chk("single_x", xloc, 100);
    chk("single_y", yloc, 50);
    chk("single_cnt0", fifo_cnt, 0);
    chk("single_busyflag", sched_idle, 0);
    pb_busy = 1'b1;
    tick();
    chk_pulses("single_hold", 3'b000);
    a_vld = 1'b1; a_cmd = mk(2'd1, 6'd7, 10'd1, 9'd2);
    tick(); a_vld = 1'b0;
    chk("wait_cnt", fifo_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pulses("wait_nopulse", 3'b000);
    end
    pb_busy = 1'b0;
    tick();
    chk_pulses("wait_idle_nopulse", 3'b000);
    chk("wait_idle_cnt", fifo_cnt, 1);
    tick();
    chk_pulses("rem_pulse", 3'b010);
    chk("rem_indx", image_indx, 7);
    chk("rem_x", xloc, 1);
    chk("rem_y", yloc, 2);
    tick(); tick(); tick();
    chk("back_idle", sched_idle, 1);

    // Round-robin after reset
    rst = 1'b1; tick(); rst = 1'b0;
    pb_busy = 1'b1;
    a_vld = 1'b1; b_vld = 1'b1;
    a_cmd = mk(2'd0, 6'd1, 10'd11, 9'd12);
    b_cmd = mk(2'd2, 6'd2, 10'd21, 9'd22);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_a_rdy", a_rdy, (i % 2 == 0) ? 1 : 0);
      chk("rr_b_rdy", b_rdy, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    b_vld = 1'b0;
    chk("rr_cnt", fifo_cnt, 4);

    // Fill to DEPTH with A only, then the extra push waits for a pop
    for (int i = 0; i < 4; i++) begin
      #1 chk("fill_a_rdy", a_rdy, 1);
      tick();
    end
    chk("full_cnt", fifo_cnt, 8);
    chk("full_a_rdy", a_rdy, 0);
    tick();
    chk("full_hold_cnt", fifo_cnt, 8);
    chk("full_hold_rdy", a_rdy, 0);
    pb_busy = 1'b0;
    tick();
    chk("full_pop_cnt", fifo_cnt, 7);
    chk_pulses("full_pop_pulse", 3'b100);
    chk("full_pop_x", xloc, 11);
    chk("ninth_rdy", a_rdy, 1);
    pb_busy = 1'b1;
    tick(); a_vld = 1'b0;
    chk("ninth_cnt", fifo_cnt, 8);

    // Reset while in S_WAIT with a full queue
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_cnt", fifo_cnt, 0);
    chk("mrst_idle", sched_idle, 1);
    chk("mrst_loc", {image_indx, fnt_indx, xloc, yloc}, 0);
    chk_pulses("mrst_pulses", 3'b000);
    tick(); tick();
    pb_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_pulses("mrst_quiet", 3'b000);
    end

    // Reserved op is dropped, following ADD_FNT issues
    a_vld = 1'b1; a_cmd = mk(2'd3, 6'd9, 10'd3, 9'd4);
    tick();
    a_cmd = mk(2'd2, 6'd41, 10'd0, 9'd0);
    tick(); a_vld = 1'b0;
    chk("rsvd_err", err_op, 1);
    chk_pulses("rsvd_nopulse", 3'b000);
    chk("rsvd_cnt", fifo_cnt, 1);
    tick();
    chk_pulses("fnt_pulse", 3'b001);
    chk("fnt_indx", fnt_indx, 41);
    chk("fnt_img_indx", image_indx, 9);
    chk("fnt_err_kept", err_op, 1);
    tick(); tick(); tick();
    // Set and clear together: set wins
    a_vld = 1'b1; a_cmd = mk(2'd3, 6'd0, 10'd0, 9'd0);
    tick(); a_vld = 1'b0; err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    chk("setwins_err", err_op, 1);
    chk_pulses("setwins_nopulse", 3'b000);
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    chk("clr_err", err_op, 0);

`ifdef VBLANK_GATE_EN
    vblank = 1'b0;
    a_vld = 1'b1; a_cmd = mk(2'd1, 6'd3, 10'd5, 9'd6);
    tick(); a_vld = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_pulses("vb_gated", 3'b000);
    end
    vblank = 1'b1;
    tick();
    chk_pulses("vb_pulse", 3'b010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
